sqrt_f32_sequencer: RTL and testbench
=====================================

SQRT_F32_SEQUENCER -- requirements
Module: sqrt_f32_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, operand queue entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 1023, max WAIT cycles before abort.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand offered.
REQ-006 in_ready  output  1  operand queue can accept.
REQ-007 in_a  input  32  IEEE-754 single operand.
REQ-008 out_valid  output  1  result held.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_sqrt  output  32  IEEE-754 single result.
REQ-011 out_flags  output  3  {timeout, invalid, bypass}.
REQ-012 core_rst  output  1  reset/start to downstream f32 square-root core, registered.
REQ-013 core_a  output  32  operand to core, registered.
REQ-014 core_rdy  input  1  core result valid.
REQ-015 core_sqrt  input  32  core result.

Function
REQ-016 Queue write SHALL occur on in_valid && in_ready; in_ready = !full, from registered count; no write while full, even if popping the same cycle.
REQ-017 Queue SHALL be FIFO-ordered; results SHALL leave in acceptance order.
REQ-018 FSM states: IDLE, LAUNCH, WAIT, HOLD.
REQ-019 IDLE with queue non-empty: pop at the next edge into the operand register, then classify it.
REQ-020 Bypass classes, applied at pop (no core launch, next state HOLD, bypass flag set): exp==0 -> {sign,31'h0}; +inf -> 0x7F800000; NaN -> 0x7FC00000 with invalid flag; negative non-zero including -inf -> 0x7FC00000 with invalid flag.
REQ-021 Otherwise next state SHALL be LAUNCH, with core_a loaded from the operand register.
REQ-022 LAUNCH: core_rst SHALL be 1 for exactly one cycle; core_a SHALL remain stable from LAUNCH until WAIT exits.
REQ-023 WAIT: core_rst=0; the timeout counter increments each cycle; core_rdy SHALL be sampled only in WAIT.
REQ-024 WAIT with core_rdy=1: out_sqrt <= {1'b0, core_sqrt[30:0]}, flags 000, next state HOLD, core_rst <= 1.
REQ-025 WAIT with counter == TIMEOUT and core_rdy=0: out_sqrt <= 0x7FC00000, flags 100, next state HOLD, core_rst <= 1.
REQ-026 If core_rdy and timeout coincide, core_rdy wins.
REQ-027 HOLD: out_valid=1; out_sqrt and out_flags SHALL stay stable until out_valid && out_ready.
REQ-028 On the HOLD handshake: go to IDLE, clear out_valid, clear the counter.
REQ-029 Handshake with the queue non-empty: the next pop is one edge later via IDLE (one idle cycle minimum).
REQ-030 core_rst SHALL be 1 in every state except WAIT.
REQ-031 Latency, accept edge to out_valid high: bypass = 2 edges; core path = 3 + core cycles.
REQ-032 Queue accepts continue during any state while not full.

Reset
REQ-033 rst=1 SHALL immediately set: state IDLE, queue empty, in_ready 1, out_valid 0, out_sqrt 0, out_flags 0, core_rst 1, core_a 0, counter 0.
REQ-034 Reset mid-operation SHALL discard queued, in-flight and held results; no output after release until a new accept.
REQ-035 First accept is possible on the first rising edge after rst falls.

Verification
REQ-036 in_a=0x40800000; core model returns 0x40000000 after 20 WAIT cycles -> core_rst low exactly 20 cycles after a single 1-cycle high pulse in LAUNCH; out_sqrt=0x40000000, flags=000.
REQ-037 in_a=0xC0800000, then 0x80000000, then 0x7F800000 -> outputs 0x7FC00000/011, 0x80000000/001, 0x7F800000/001 in order; core_rst never low.
REQ-038 TIMEOUT=15, core_rdy tied 0, in_a=0x41100000 -> out_valid 16 WAIT cycles after LAUNCH; out_sqrt=0x7FC00000, flags=100; core_rst high thereafter.
REQ-039 out_ready=0, offer 8 operands back-to-back -> exactly FIFO_DEPTH+1 accepted, then in_ready=0; with out_ready=1 all accepted results emerge in order and out_sqrt stays stable while stalled.
REQ-040 rst pulse during WAIT with 2 queued -> out_valid=0, in_ready=1, core_rst=1 while reset; no stale results afterwards.
REQ-041 core_rdy=1 on the same cycle the counter reaches TIMEOUT -> core result delivered, flags=000.

Source files
------------

// File: rtl/sqrt_f32_sequencer.sv
// ============================================================================
//  Module      : sqrt_f32_sequencer
//  Description : Operand queue and sequencer in front of an external
//                single-precision square-root core. Special operands
//                (zero/denormal, +inf, NaN, negative) are answered directly
//                without starting the core. Every other operand is launched
//                into the core, and the result is taken when the core reports
//                ready, or a quiet NaN is returned when the core times out.
//                Results are held until the consumer takes them.
//
//  Ports
//    clk        : single clock, all state on the rising edge
//    rst        : asynchronous active-high reset
//    in_valid   : operand offered
//    in_ready   : operand queue can accept (not full)
//    in_a       : IEEE-754 single operand
//    out_valid  : result held
//    out_ready  : consumer accepts result
//    out_sqrt   : IEEE-754 single result
//    out_flags  : {timeout, invalid, bypass}
//    core_rst   : registered reset/start to the core (low only while waiting)
//    core_a     : registered operand to the core
//    core_rdy   : core result valid
//    core_sqrt  : core result
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sqrt_f32_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sqrt,
    output logic [2:0]  out_flags,
    output logic        core_rst,
    output logic [31:0] core_a,
    input  logic        core_rdy,
    input  logic [31:0] core_sqrt
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_TMO_W-1:0] c_TMO_LIMIT = c_TMO_W'(TIMEOUT);

    localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;
    localparam logic [31:0] c_PINF      = 32'h7F80_0000;
    localparam logic [31:0] c_MAG_MASK  = 32'h7FFF_FFFF;

    localparam logic [2:0]  c_FLAG_NONE    = 3'b000;
    localparam logic [2:0]  c_FLAG_BYPASS  = 3'b001;
    localparam logic [2:0]  c_FLAG_INVALID = 3'b010;
    localparam logic [2:0]  c_FLAG_TIMEOUT = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // ------------------------------------------------------------------
    // Operand queue
    // ------------------------------------------------------------------
    logic [31:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_head;

    // in_ready depends only on the registered count, so a pop in the same
    // cycle never opens a slot for a write while full.
    assign in_ready = (r_count != c_FULL);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Special-operand classification of the queue head
    // ------------------------------------------------------------------
    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic        w_bypass;
    logic [31:0] w_byp_sqrt;
    logic [2:0]  w_byp_flags;

    assign w_sign = w_head[31];
    assign w_exp  = w_head[30:23];
    assign w_frac = w_head[22:0];

    // Order matters: a zero exponent wins over the sign test, so -0 and
    // negative denormals return a signed zero rather than NaN.
    always_comb begin
        w_bypass    = 1'b1;
        w_byp_sqrt  = c_QNAN;
        w_byp_flags = c_FLAG_INVALID | c_FLAG_BYPASS;
        if (w_exp == 8'h00) begin
            w_byp_sqrt  = {w_sign, 31'h0};
            w_byp_flags = c_FLAG_BYPASS;
        end else if ((w_exp == 8'hFF) && (w_frac != '0)) begin
            w_byp_sqrt  = c_QNAN;
            w_byp_flags = c_FLAG_INVALID | c_FLAG_BYPASS;
        end else if (w_sign) begin
            w_byp_sqrt  = c_QNAN;
            w_byp_flags = c_FLAG_INVALID | c_FLAG_BYPASS;
        end else if (w_exp == 8'hFF) begin
            w_byp_sqrt  = c_PINF;
            w_byp_flags = c_FLAG_BYPASS;
        end else begin
            w_bypass = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_tmo_hit;
    logic               w_wait_exit;

    assign w_tmo_hit   = (r_tmo_cnt == c_TMO_LIMIT);
    assign w_wait_exit = core_rdy || w_tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_next_state = w_bypass ? S_HOLD : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_wait_exit) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [31:0] r_out_sqrt;
    logic [2:0]  r_out_flags;
    logic        r_core_rst;
    logic [31:0] r_core_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_sqrt  <= '0;
            r_out_flags <= '0;
            r_core_rst  <= 1'b1;
            r_core_a    <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            // Core is released only while the sequencer is in WAIT.
            r_core_rst <= (w_next_state != S_WAIT);

            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_bypass) begin
                            r_out_sqrt  <= w_byp_sqrt;
                            r_out_flags <= w_byp_flags;
                        end else begin
                            // Held unchanged through LAUNCH and WAIT.
                            r_core_a <= w_head;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_tmo_cnt <= '0;
                end
                S_WAIT: begin
                    if (core_rdy) begin
                        // A core result always reports a positive root.
                        r_out_sqrt  <= core_sqrt & c_MAG_MASK;
                        r_out_flags <= c_FLAG_NONE;
                    end else if (w_tmo_hit) begin
                        r_out_sqrt  <= c_QNAN;
                        r_out_flags <= c_FLAG_TIMEOUT;
                    end else begin
                        // Not advanced on the exit cycle, so the counter
                        // never wraps past TIMEOUT.
                        r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_tmo_cnt <= '0;
                    end
                end
                default: begin
                    r_tmo_cnt <= '0;
                end
            endcase
        end
    end

    assign out_valid = (r_state == S_HOLD);
    assign out_sqrt  = r_out_sqrt;
    assign out_flags = r_out_flags;
    assign core_rst  = r_core_rst;
    assign core_a    = r_core_a;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_f32_sequencer.sv
// ============================================================================
//  Module      : tb_sqrt_f32_sequencer
//  Description : Scoreboard bench for sqrt_f32_sequencer. Two instances are
//                built: index 0 with the default TIMEOUT, index 1 with
//                TIMEOUT=15. Only the selected instance receives operands.
//                Each instance has a behavioural core that answers a fixed
//                table of roots after a programmable number of WAIT cycles.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sqrt_f32_sequencer;

    typedef struct packed {
        logic [31:0] s;
        logic [2:0]  f;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_a;
    logic        out_ready;
    logic        sel;
    int          core_lat;

    logic [1:0]  iv;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  core_rst;
    logic [1:0]  core_rdy;
    logic [31:0] out_sqrt  [2];
    logic [2:0]  out_flags [2];
    logic [31:0] core_a    [2];
    logic [31:0] core_sqrt [2];

    exp_t sb[$];
    int   n_chk;
    int   n_fail;
    int   low_cnt  [2];
    int   low_runs [2];
    logic prev_crst[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known roots; 100.0 is answered with its sign bit set on purpose.
    function automatic logic [31:0] core_model(input logic [31:0] a);
        case (a)
            32'h4080_0000: return 32'h4000_0000;   // 4   -> 2
            32'h4110_0000: return 32'h4040_0000;   // 9   -> 3
            32'h3F80_0000: return 32'h3F80_0000;   // 1   -> 1
            32'h4180_0000: return 32'h4080_0000;   // 16  -> 4
            32'h42C8_0000: return 32'hC120_0000;   // 100 -> -10 raw
            default:       return 32'h7F7F_FFFF;
        endcase
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g_dut
        int cnt = 0;

        assign iv[i] = in_valid && (sel == 1'(i));

        sqrt_f32_sequencer #(
            .FIFO_DEPTH (4),
            .TIMEOUT    ((i == 0) ? 1023 : 15)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[i]),
            .in_ready  (in_ready[i]),
            .in_a      (in_a),
            .out_valid (out_valid[i]),
            .out_ready (out_ready),
            .out_sqrt  (out_sqrt[i]),
            .out_flags (out_flags[i]),
            .core_rst  (core_rst[i]),
            .core_a    (core_a[i]),
            .core_rdy  (core_rdy[i]),
            .core_sqrt (core_sqrt[i])
        );

        // cnt = number of released cycles already completed, so core_rdy is
        // high during released cycle number core_lat.
        always @(posedge clk) cnt <= core_rst[i] ? 0 : cnt + 1;
        assign core_rdy[i]  = (core_lat > 0) && !core_rst[i] && (cnt == core_lat - 1);
        assign core_sqrt[i] = core_model(core_a[i]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_crst[0] = 1'b1;
                prev_crst[1] = 1'b1;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (!core_rst[i]) low_cnt[i]++;
                    if (!core_rst[i] && prev_crst[i]) low_runs[i]++;
                    prev_crst[i] = core_rst[i];
                    if (out_valid[i]) begin
                        if (sb.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_output dut%0d: got %h/%b, expected no output",
                                     i, out_sqrt[i], out_flags[i]);
                        end else if (out_ready) begin
                            e = sb.pop_front();
                            check($sformatf("out_sqrt dut%0d", i), out_sqrt[i], e.s);
                            check($sformatf("out_flags dut%0d", i), 32'(out_flags[i]), 32'(e.f));
                        end else begin
                            check($sformatf("stall_sqrt dut%0d", i), out_sqrt[i], sb[0].s);
                            check($sformatf("stall_flags dut%0d", i), 32'(out_flags[i]), 32'(sb[0].f));
                        end
                    end
                end
            end
        end
    endtask

    // All stimulus tasks start and end at posedge+1.
    task automatic push_op(input logic [31:0] a, input logic [31:0] es, input logic [2:0] ef);
        int n;
        n = 0;
        in_a     = a;
        in_valid = 1'b1;
        while (!in_ready[sel] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready[sel]) begin
            check("push_in_ready", 32'(in_ready[sel]), 32'd1);
        end else begin
            sb.push_back('{s: es, f: ef});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic edges_to_valid(output int n);
        n = 0;
        while (!out_valid[sel] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_remaining", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] s;
        logic [2:0]  f;
    } vec_t;

    initial begin
        int   n;
        int   base_low;
        int   base_runs;
        int   accepted;
        vec_t tab [8];

        tab[0] = '{a: 32'h4080_0000, s: 32'h4000_0000, f: 3'b000};
        tab[1] = '{a: 32'hC080_0000, s: 32'h7FC0_0000, f: 3'b011};
        tab[2] = '{a: 32'h4110_0000, s: 32'h4040_0000, f: 3'b000};
        tab[3] = '{a: 32'h0000_0000, s: 32'h0000_0000, f: 3'b001};
        tab[4] = '{a: 32'h42C8_0000, s: 32'h4120_0000, f: 3'b000};
        tab[5] = '{a: 32'h7FC0_0001, s: 32'h7FC0_0000, f: 3'b011};
        tab[6] = '{a: 32'h3F80_0000, s: 32'h3F80_0000, f: 3'b000};
        tab[7] = '{a: 32'h4180_0000, s: 32'h4080_0000, f: 3'b000};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        out_ready = 1'b1;
        sel       = 1'b0;
        core_lat  = 0;
        n_chk     = 0;
        n_fail    = 0;
        for (int i = 0; i < 2; i++) begin
            low_cnt[i]   = 0;
            low_runs[i]  = 0;
            prev_crst[i] = 1'b1;
        end

        fork
            monitor_loop();
        join_none

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_in_ready dut%0d", i), 32'(in_ready[i]), 32'd1);
            check($sformatf("rst_out_valid dut%0d", i), 32'(out_valid[i]), 32'd0);
            check($sformatf("rst_out_sqrt dut%0d", i), out_sqrt[i], 32'd0);
            check($sformatf("rst_out_flags dut%0d", i), 32'(out_flags[i]), 32'd0);
            check($sformatf("rst_core_rst dut%0d", i), 32'(core_rst[i]), 32'd1);
            check($sformatf("rst_core_a dut%0d", i), core_a[i], 32'd0);
        end
        rst = 1'b0;

        // Core path: sqrt(4) after 20 WAIT cycles, accepted on the first edge
        sel       = 1'b0;
        core_lat  = 20;
        base_low  = low_cnt[0];
        base_runs = low_runs[0];
        push_op(32'h4080_0000, 32'h4000_0000, 3'b000);
        edges_to_valid(n);
        check("core_latency_edges", 32'(n), 32'd22);
        drain();
        check("core_rst_low_cycles", 32'(low_cnt[0] - base_low), 32'd20);
        check("core_rst_low_runs", 32'(low_runs[0] - base_runs), 32'd1);

        // Bypass classes, in order, never touching the core
        base_low = low_cnt[0];
        push_op(32'hC080_0000, 32'h7FC0_0000, 3'b011);
        edges_to_valid(n);
        check("bypass_latency_edges", 32'(n), 32'd1);
        push_op(32'h8000_0000, 32'h8000_0000, 3'b001);
        push_op(32'h7F80_0000, 32'h7F80_0000, 3'b001);
        push_op(32'hFF80_0000, 32'h7FC0_0000, 3'b011);
        push_op(32'h0000_0001, 32'h0000_0000, 3'b001);
        push_op(32'h8000_0001, 32'h8000_0000, 3'b001);
        drain();
        check("bypass_core_rst_low", 32'(low_cnt[0] - base_low), 32'd0);

        // Timeout with core_rdy tied low on the TIMEOUT=15 instance
        sel      = 1'b1;
        core_lat = 0;
        base_low = low_cnt[1];
        push_op(32'h4110_0000, 32'h7FC0_0000, 3'b100);
        edges_to_valid(n);
        check("timeout_latency_edges", 32'(n), 32'd18);
        drain();
        check("timeout_wait_cycles", 32'(low_cnt[1] - base_low), 32'd16);
        base_low = low_cnt[1];
        repeat (10) @(posedge clk);
        #1;
        check("timeout_core_rst_high", 32'(core_rst[1]), 32'd1);
        check("timeout_no_relaunch", 32'(low_cnt[1] - base_low), 32'd0);

        // core_rdy on the very cycle the counter reaches TIMEOUT
        core_lat = 16;
        push_op(32'h4110_0000, 32'h4040_0000, 3'b000);
        drain();
        // One cycle later is a timeout
        core_lat = 17;
        push_op(32'h4110_0000, 32'h7FC0_0000, 3'b100);
        drain();

        // Back-pressure: 8 offers while out_ready=0
        sel       = 1'b0;
        core_lat  = 3;
        out_ready = 1'b0;
        accepted  = 0;
        for (int k = 0; k < 8; k++) begin
            in_a     = tab[k].a;
            in_valid = 1'b1;
            if (in_ready[0]) begin
                sb.push_back('{s: tab[k].s, f: tab[k].f});
                accepted++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("fifo_accepted", 32'(accepted), 32'd5);
        check("fifo_full_in_ready", 32'(in_ready[0]), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset during WAIT with two operands queued
        core_lat = 20;
        push_op(32'h4080_0000, 32'h4000_0000, 3'b000);
        push_op(32'h4110_0000, 32'h4040_0000, 3'b000);
        push_op(32'h4180_0000, 32'h4080_0000, 3'b000);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_in_wait", 32'(core_rst[0]), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("mid_rst_core_rst", 32'(core_rst[0]), 32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("post_rst_no_output", 32'(out_valid[0]), 32'd0);
        check("post_rst_core_idle", 32'(core_rst[0]), 32'd1);
        push_op(32'h3F80_0000, 32'h3F80_0000, 3'b000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
